wifi_uart_tx: RTL and testbench

WIFI_UART_TX -- requirements
Module: wifi_uart_tx

---
 rtl/wifi_uart_pkg.sv | 24 ++
 rtl/wifi_uart_tx_if.sv | 30 +++
 rtl/wifi_uart_fifo.sv | 63 ++++++
 rtl/wifi_uart_tx.sv | 147 ++++++++++++++
 tb/tb_wifi_uart_tx.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/wifi_uart_pkg.sv
// Shared definitions for the WiFi-module UART link (transmitter and the
// matching receiver): 8N1 frame constants, FSM state encodings and the
// clocks-per-bit divisor computation.
package wifi_uart_pkg;

  // 8N1 framing
  localparam int   DATA_BITS  = 8;
  localparam int   FRAME_BITS = 1 + DATA_BITS + 1;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

  // Line FSM states
  typedef logic [1:0] uart_state_t;
  localparam uart_state_t ST_IDLE  = 2'd0;
  localparam uart_state_t ST_START = 2'd1;
  localparam uart_state_t ST_DATA  = 2'd2;
  localparam uart_state_t ST_STOP  = 2'd3;

  // Clocks per line bit, rounded to nearest: round(clk_hz / baud).
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/wifi_uart_tx_if.sv
// Byte-stream + serial-line bundle for wifi_uart_tx.
//   tx_data/tx_valid/tx_ready : byte push handshake into the TX FIFO
//   uart_txd                  : serial line to the WiFi module RX pin
//   uart_cts_n                : clear-to-send from the WiFi module (async)
//   fifo_level, busy          : status
// master = byte producer / line partner, slave = the transmitter.
interface wifi_uart_tx_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             uart_txd;
  logic             uart_cts_n;
  logic [LVL_W-1:0] fifo_level;
  logic             busy;

  modport master (
    output tx_data, tx_valid, uart_cts_n,
    input  tx_ready, uart_txd, fifo_level, busy
  );

  modport slave (
    input  tx_data, tx_valid, uart_cts_n,
    output tx_ready, uart_txd, fifo_level, busy
  );

endinterface

// File: rtl/wifi_uart_fifo.sv
// Synchronous single-clock FIFO with a registered occupancy count.
//   clk, rst_n       : clock, async active-low reset
//   push_i, wdata_i  : write request/data (ignored when full)
//   pop_i, rdata_o   : read request (ignored when empty), head entry
//   level_o          : entries held, 0..DEPTH
//   full_o, empty_o  : decoded from level_o
module wifi_uart_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LVL_W = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [W-1:0]     wdata_i,
  input  logic             pop_i,
  output logic [W-1:0]     rdata_o,
  output logic [LVL_W-1:0] level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_comb begin
    level_d = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Storage needs no reset: level/pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/wifi_uart_tx.sv
// 8N1 UART transmitter toward a WiFi module, with CTS flow control and a
// byte FIFO in front of the line.
//   clk_clk       : system clock
//   reset_reset_n : async active-low reset
//   bus (slave)   : tx_data/tx_valid/tx_ready push port, uart_txd line,
//                   uart_cts_n flow control, fifo_level and busy status
module wifi_uart_tx
  import wifi_uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input logic           clk_clk,
  input logic           reset_reset_n,
  wifi_uart_tx_if.slave bus
);

  localparam int DIV   = baud_div(CLK_HZ, BAUD);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  // CTS synchronizer; resets to "not clear" so nothing leaves early.
  logic cts_meta_q, cts_s_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cts_meta_q <= 1'b1;
      cts_s_q    <= 1'b1;
    end else begin
      cts_meta_q <= bus.uart_cts_n;
      cts_s_q    <= cts_meta_q;
    end
  end

  // FIFO
  logic             push, pop;
  logic [7:0]       head;
  logic [LVL_W-1:0] level;
  logic             full, empty;

  assign push = bus.tx_valid & ~full;

  wifi_uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .push_i  (push),
    .wdata_i (bus.tx_data),
    .pop_i   (pop),
    .rdata_o (head),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  // Line FSM
  uart_state_t      state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             bit_end, can_start;

  assign bit_end   = (baud_cnt_q == CNT_W'(DIV - 1));
  assign can_start = ~empty & ~cts_s_q;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    txd_d      = txd_q;
    pop        = 1'b0;
    baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        baud_cnt_d = '0;
        txd_d      = STOP_BIT;
        if (can_start) begin
          state_d   = ST_START;
          pop       = 1'b1;
          shift_d   = head;
          bit_cnt_d = '0;
          txd_d     = START_BIT;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          txd_d   = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
            state_d = ST_STOP;
            txd_d   = STOP_BIT;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
          end
        end
      end
      ST_STOP: begin
        // End of stop bit doubles as the IDLE decision point so that
        // queued bytes go out back-to-back without an extra idle bit.
        if (bit_end) begin
          if (can_start) begin
            state_d   = ST_START;
            pop       = 1'b1;
            shift_d   = head;
            bit_cnt_d = '0;
            txd_d     = START_BIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = STOP_BIT;
      end
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
    end
  end

  assign bus.uart_txd   = txd_q;
  assign bus.tx_ready   = ~full;
  assign bus.fifo_level = level;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wifi_uart_tx.sv
module tb_wifi_uart_tx;

  // 1 MHz / 96 kbaud -> 10.42 -> 10 clocks per bit
  localparam int DIV_TB = 10;
  localparam int FRAME  = 10 * DIV_TB;

  logic gclk = 1'b0;
  logic grst_n = 1'b0;
  always #5 gclk = ~gclk;

  wifi_uart_tx_if #(.FIFO_DEPTH(16)) bus ();

  wifi_uart_tx #(.CLK_HZ(1000000), .BAUD(96000), .FIFO_DEPTH(16)) dut (
    .clk_clk       (gclk),
    .reset_reset_n (grst_n),
    .bus           (bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int frames_done = 0;
  int cyc = 0;
  logic [7:0] sb [$];

  always @(posedge gclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic push(input logic [7:0] d);
    int n = 0;
    while (!bus.tx_ready && n < 1000) begin @(negedge gclk); n++; end
    if (!bus.tx_ready) chk("push_ready", 0, 1);
    else begin
      bus.tx_valid = 1'b1;
      bus.tx_data  = d;
      sb.push_back(d);
      @(negedge gclk);
      bus.tx_valid = 1'b0;
    end
  endtask

  task automatic wait_txd_low(input string tag);
    int n = 0;
    while (bus.uart_txd && n < 1000) begin @(negedge gclk); n++; end
    chk(tag, int'(bus.uart_txd), 0);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((bus.busy || bus.fifo_level != 0) && n < 5000) begin @(negedge gclk); n++; end
    chk(tag, int'(bus.busy), 0);
  endtask

  // Line monitor: decodes each frame cycle by cycle against the next
  // expected byte, so any bit value or bit duration error shows up.
  initial begin : mon
    logic [7:0] e, g;
    logic [9:0] fb;
    int errs;
    bit ab;
    forever begin
      @(negedge gclk);
      if (grst_n && bus.uart_txd === 1'b0) begin
        if (sb.size() == 0) begin chk("spurious_frame", 1, 0); e = '0; end
        else e = sb.pop_front();
        fb = {1'b1, e, 1'b0};
        errs = 0; ab = 0; g = '0;
        for (int b = 0; b < 10 && !ab; b++)
          for (int c = 0; c < DIV_TB && !ab; c++) begin
            if (b != 0 || c != 0) @(negedge gclk);
            if (!grst_n) ab = 1;
            else begin
              if (bus.uart_txd !== fb[b]) errs++;
              if (b >= 1 && b <= 8 && c == DIV_TB / 2) g[b-1] = bus.uart_txd;
            end
          end
        if (!ab) begin
          chk("frame_bits", errs, 0);
          chk("frame_byte", int'(g), int'(e));
          frames_done++;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt, lvl_exp, last, prev_lvl, nstart;
    bus.tx_valid   = 1'b0;
    bus.tx_data    = '0;
    bus.uart_cts_n = 1'b0;

    // reset state
    repeat (3) @(negedge gclk);
    chk("rst_txd", int'(bus.uart_txd), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_ready", int'(bus.tx_ready), 1);
    chk("rst_level", int'(bus.fifo_level), 0);
    grst_n = 1'b1;
    repeat (5) @(negedge gclk);

    // single 0x55 frame: latency, busy length
    push(8'h55);
    chk("lat_n1", int'(bus.uart_txd), 1);
    @(negedge gclk);
    chk("lat_n2", int'(bus.uart_txd), 0);
    cnt = 0;
    while (bus.busy && cnt < 1000) begin cnt++; @(negedge gclk); end
    chk("busy_len", cnt, FRAME);
    chk("idle_txd", int'(bus.uart_txd), 1);
    chk("idle_level", int'(bus.fifo_level), 0);

    // fill FIFO with CTS deasserted
    bus.uart_cts_n = 1'b1;
    repeat (4) @(negedge gclk);
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i * 8'h0B));
    chk("full_level", int'(bus.fifo_level), 16);
    chk("full_ready", int'(bus.tx_ready), 0);
    cnt = 0;
    repeat (30) begin
      @(negedge gclk);
      if (!bus.uart_txd || bus.busy) cnt++;
    end
    chk("cts_block", cnt, 0);

    // release CTS: 16 contiguous frames, level stepping down at each start
    bus.uart_cts_n = 1'b0;
    lvl_exp = 16; prev_lvl = 16; nstart = 0; n = 0; last = 0;
    while (nstart < 16 && n < 3000) begin
      @(negedge gclk); n++;
      if (int'(bus.fifo_level) != prev_lvl) begin
        lvl_exp--;
        chk("lvl_at_start", int'(bus.fifo_level), lvl_exp);
        chk("start_bit", int'(bus.uart_txd), 0);
        if (nstart > 0) chk("frame_gap", cyc - last, FRAME);
        last = cyc; nstart++;
        prev_lvl = int'(bus.fifo_level);
      end
    end
    chk("burst_frames", nstart, 16);
    wait_drain("burst_drain");

    // CTS raised mid-frame: current frame completes, next one holds
    bus.uart_cts_n = 1'b1;
    repeat (4) @(negedge gclk);
    push(8'h3C);
    push(8'hC3);
    bus.uart_cts_n = 1'b0;
    wait_txd_low("cts_f1_start");
    repeat (4 * DIV_TB) @(negedge gclk);
    bus.uart_cts_n = 1'b1;
    cnt = 0;
    while (bus.busy && cnt < 1000) begin cnt++; @(negedge gclk); end
    chk("cts_f1_rest", cnt, FRAME - 4 * DIV_TB);
    cnt = 0;
    repeat (50) begin
      @(negedge gclk);
      if (!bus.uart_txd || bus.busy) cnt++;
    end
    chk("cts_hold", cnt, 0);
    chk("cts_hold_lvl", int'(bus.fifo_level), 1);
    bus.uart_cts_n = 1'b0;
    wait_drain("cts_drain");

    // push coinciding with pop at level 3
    bus.uart_cts_n = 1'b1;
    repeat (4) @(negedge gclk);
    push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
    bus.uart_cts_n = 1'b0;
    wait_txd_low("pp_start");
    chk("pp_lvl_a", int'(bus.fifo_level), 3);
    repeat (FRAME - 1) @(negedge gclk);
    chk("pp_lvl_b", int'(bus.fifo_level), 3);
    push(8'h99);
    chk("pp_lvl_c", int'(bus.fifo_level), 3);
    chk("pp_next_start", int'(bus.uart_txd), 0);
    wait_drain("pp_drain");

    // reset during data bit 5 of 0xA3
    bus.uart_cts_n = 1'b1;
    repeat (4) @(negedge gclk);
    push(8'hA3); push(8'h11);
    bus.uart_cts_n = 1'b0;
    wait_txd_low("rst_f_start");
    repeat (6 * DIV_TB) @(negedge gclk);
    grst_n = 1'b0;
    #1;
    chk("rst_mid_txd", int'(bus.uart_txd), 1);
    chk("rst_mid_lvl", int'(bus.fifo_level), 0);
    chk("rst_mid_busy", int'(bus.busy), 0);
    chk("rst_mid_ready", int'(bus.tx_ready), 1);
    repeat (3) @(negedge gclk);
    sb.delete();
    grst_n = 1'b1;
    cnt = 0;
    repeat (300) begin
      @(negedge gclk);
      if (!bus.uart_txd || bus.busy) cnt++;
    end
    chk("post_rst_quiet", cnt, 0);

    chk("frames_total", frames_done, 24);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
